// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// byte width, serializer bit period and the default mid-message hold limit.
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int UART_CLKS_PER_BIT    = 10416;
  localparam int HOLD_TIMEOUT_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

  // Successor of a requester index, wrapping N-1 back to 0.
  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first set request bit
// found searching upward from ptr_i, wrapping past the top index.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    found_o = 1'b0;
    idx_o   = '0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        found_o = 1'b1;
        idx_o   = IW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART serializer; a grant covers a whole
// message so bytes of different requesters never interleave on the line.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int DATA_W       = UART_DATA_W,
  parameter  int HOLD_TIMEOUT = HOLD_TIMEOUT_DEFAULT,
  localparam int IW           = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic                    grant_active,
  output logic [IW-1:0]           grant_id
);

  localparam int             CNT_W     = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TIMEOUT - 1);

  arb_state_e        state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     grant_id_q;
  logic              grant_active_q;
  logic              tx_start_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              last_q;
  logic [CNT_W-1:0]  hold_cnt_q;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic              accept;
  logic [IW-1:0]     ptr_d;

  rr_pick #(.N(N_REQ)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign accept = (state_q == GRANT) && req_valid[grant_id_q] && !tx_busy;
  assign ptr_d  = IW'(next_idx(int'(grant_id_q), N_REQ));

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      last_q         <= 1'b0;
      hold_cnt_q     <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q     <= pick_idx;
            grant_active_q <= 1'b1;
            hold_cnt_q     <= '0;
            state_q        <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            tx_data_q  <= req_data[int'(grant_id_q)*DATA_W +: DATA_W];
            last_q     <= req_last[grant_id_q];
            tx_start_q <= 1'b1;
            state_q    <= WAIT_BUSY;
          end else if (!req_valid[grant_id_q]) begin
            // Only an owner stall counts; serializer backpressure does not.
            if (hold_cnt_q == HOLD_LAST) begin
              ptr_q          <= ptr_d;
              grant_active_q <= 1'b0;
              state_q        <= IDLE;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_q) begin
              ptr_q          <= ptr_d;
              grant_active_q <= 1'b0;
              state_q        <= IDLE;
            end else begin
              hold_cnt_q <= '0;
              state_q    <= GRANT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed messages, a short behavioural
// serializer, and a monitor checking every accept and every start pulse.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int HOLD     = 16;
  localparam int BUSY_CYC = 12;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic            ser_busy;
  logic            force_busy;
  logic            grant_active;
  logic [1:0]      grant_id;

  int n_checks;
  int n_fail;

  typedef struct {
    int          id;
    logic [7:0]  d;
  } exp_t;

  exp_t       exp_acc[$];
  exp_t       exp_tx[$];
  logic [8:0] rq[N][$];

  assign tx_busy = ser_busy | force_busy;

  uart_tx_arbiter #(
    .N_REQ        (N),
    .DATA_W       (DW),
    .HOLD_TIMEOUT (HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue a byte for requester id; expected bytes also go to the scoreboard.
  task automatic send(input int id, input logic [7:0] d, input logic l, input bit expect_it);
    exp_t e;
    rq[id].push_back({l, d});
    if (expect_it) begin
      e.id = id;
      e.d  = d;
      exp_acc.push_back(e);
      exp_tx.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    bit empty;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) empty = 1'b0;
      done = empty && exp_acc.size() == 0 && exp_tx.size() == 0 && !grant_active && !tx_busy;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_busy(input logic level, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      seen = (tx_busy == level);
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Requester driver: present the queue head, pop it once it was accepted.
  initial begin
    logic [N-1:0] fire;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i]          = 1'b1;
          req_last[i]           = rq[i][0][8];
          req_data[i*DW +: DW]  = rq[i][0][7:0];
        end else begin
          req_valid[i]          = 1'b0;
          req_last[i]           = 1'b0;
          req_data[i*DW +: DW]  = '0;
        end
      end
    end
  end

  // Serializer model: busy rises the cycle after tx_start, aborts on reset.
  initial begin
    int cnt;
    ser_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        @(posedge clk);
        #1 ser_busy = 1'b1;
        cnt = 0;
        while (cnt < BUSY_CYC && rst_n) begin
          @(posedge clk);
          cnt++;
        end
        #1 ser_busy = 1'b0;
      end
    end
  end

  // Monitor: each accept and each start pulse must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_ready != '0) begin
          if (exp_acc.size() == 0) check("ready_unexpected", 32'(req_ready), 32'd0);
          else begin
            e = exp_acc.pop_front();
            check("ready_owner", 32'(req_ready), 32'(1) << e.id);
          end
        end
        if (tx_start) begin
          if (exp_tx.size() == 0) check("start_unexpected", 32'(tx_start), 32'd0);
          else begin
            e = exp_tx.pop_front();
            check("tx_data", 32'(tx_data), 32'(e.d));
            check("tx_owner", 32'(grant_id), 32'(e.id));
          end
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ready_cnt;
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    force_busy = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_grant_active", 32'(grant_active), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single requester, cycle-exact latency
    @(negedge clk);
    send(2, 8'h41, 1'b1, 1'b1);
    @(negedge clk);
    check("t1_c0_grant_active", 32'(grant_active), 32'd0);
    @(negedge clk);
    check("t1_c1_grant_active", 32'(grant_active), 32'd1);
    check("t1_c1_grant_id", 32'(grant_id), 32'd2);
    check("t1_c1_req_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    check("t1_c2_tx_start", 32'(tx_start), 32'd1);
    check("t1_c2_tx_data", 32'(tx_data), 32'h41);
    check("t1_c2_req_ready", 32'(req_ready), 32'd0);
    wait_drain("t1_drain");
    // ptr is now 3: of {1,3}, requester 3 goes first
    send(3, 8'h33, 1'b1, 1'b1);
    send(1, 8'h11, 1'b1, 1'b1);
    wait_drain("t1_ptr_drain");

    // Message lock: "HI" from 0 completes before requester 1 is served
    send(0, 8'h48, 1'b0, 1'b1);
    send(0, 8'h49, 1'b1, 1'b1);
    send(1, 8'h55, 1'b1, 1'b1);
    wait_drain("t2_drain");

    // Hold timeout: requester 3 stalls after a non-last byte
    send(3, 8'h10, 1'b0, 1'b1);
    wait_busy(1'b1, "t4_busy_rise");
    wait_busy(1'b0, "t4_busy_fall");
    repeat (HOLD) @(negedge clk);
    check("t4_held_last_cycle", 32'(grant_active), 32'd1);
    @(negedge clk);
    check("t4_released", 32'(grant_active), 32'd0);
    check("t4_no_start", 32'(tx_start), 32'd0);

    // Fairness from ptr 0: order 0,1,2,3,0
    send(0, 8'hA0, 1'b1, 1'b1);
    send(1, 8'hA1, 1'b1, 1'b1);
    send(2, 8'hA2, 1'b1, 1'b1);
    send(3, 8'hA3, 1'b1, 1'b1);
    send(0, 8'hA4, 1'b1, 1'b1);
    wait_drain("t3_drain");

    // Serializer busy at grant entry
    force_busy = 1'b1;
    send(1, 8'h77, 1'b1, 1'b1);
    ready_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (req_ready != '0) ready_cnt++;
    end
    check("t5_ready_while_busy", 32'(ready_cnt), 32'd0);
    check("t5_grant_active", 32'(grant_active), 32'd1);
    check("t5_grant_id", 32'(grant_id), 32'd1);
    @(posedge clk);
    #1 force_busy = 1'b0;
    @(negedge clk);
    check("t5_accept", 32'(req_ready), 32'b0010);
    wait_drain("t5_drain");

    // Reset during WAIT_DONE of a two-byte message
    send(2, 8'h31, 1'b0, 1'b1);
    send(2, 8'h32, 1'b1, 1'b0);
    wait_busy(1'b1, "t6_busy_rise");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_grant_active", 32'(grant_active), 32'd0);
    check("t6_grant_id", 32'(grant_id), 32'd0);
    check("t6_req_ready", 32'(req_ready), 32'd0);
    check("t6_tx_start", 32'(tx_start), 32'd0);
    check("t6_tx_data", 32'(tx_data), 32'd0);
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_acc.delete();
    exp_tx.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // ptr back at 0: order 0,1,2,3
    send(0, 8'hC0, 1'b1, 1'b1);
    send(1, 8'hC1, 1'b1, 1'b1);
    send(2, 8'hC2, 1'b1, 1'b1);
    send(3, 8'hC3, 1'b1, 1'b1);
    wait_drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
